// File: rtl/iter_muldiv_pkg.sv
// iter_muldiv_pkg: operation/state types and default width shared by the
// iterative multiply/divide controller, its interface and its bench.
package iter_muldiv_pkg;
   localparam int DEFAULT_WIDTH = 8;
   typedef enum logic {OP_MUL, OP_DIV} op_e;
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
endpackage

// File: rtl/iter_muldiv_ctrl_if.sv
// iter_muldiv_ctrl_if: start/busy/done front-side bundle of the iterative
// multiply/divide controller; master issues requests, slave is the controller.
interface iter_muldiv_ctrl_if #(parameter int WIDTH = iter_muldiv_pkg::DEFAULT_WIDTH);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] remainder;
   logic             ovf;
   logic             dbz;
   modport master (output start, op, opa, opb,
                   input  busy, done, result, remainder, ovf, dbz);
   modport slave  (input  start, op, opa, opb,
                   output busy, done, result, remainder, ovf, dbz);
endinterface

// File: rtl/iter_muldiv_ctrl_addsub.sv
// addsub: shared unsigned WIDTH-bit adder/subtractor (add_sub=1 adds);
// cout is the carry-out on add and the borrow on subtract.
module addsub #(parameter int WIDTH = 8) (
   input  logic             add_sub,
   input  logic [WIDTH-1:0] dataa,
   input  logic [WIDTH-1:0] datab,
   output logic [WIDTH-1:0] result,
   output logic             cout
);
   logic [WIDTH:0] sum;
   assign sum = add_sub ? {1'b0, dataa} + {1'b0, datab} : {1'b0, dataa} - {1'b0, datab};
   assign {cout, result} = sum;
endmodule

// File: rtl/iter_muldiv_ctrl.sv
// iter_muldiv_ctrl: sequencer running unsigned multiply (repeated add) and divide
// (repeated subtract) on one shared addsub. ITER_MULDIV_SAT_EN saturates overflowing products.
module iter_muldiv_ctrl
   import iter_muldiv_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH)
(
   input logic               clk,
   input logic               reset,
   iter_muldiv_ctrl_if.slave bus
);
   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, cnt_q, cnt_d, quo_q, quo_d;
   logic [WIDTH-1:0] result_q, result_d, rem_q, rem_d;
   logic             busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, dbz_q, dbz_d;
   logic             add_sub, cout;
   logic [WIDTH-1:0] sum, mul_res;
   // acc doubles as the running remainder while dividing
   assign add_sub = state_q != DIV;
   addsub #(.WIDTH(WIDTH)) u_addsub (
      .add_sub(add_sub),
      .dataa  (acc_q),
      .datab  (add_sub ? a_q : b_q),
      .result (sum),
      .cout   (cout)
   );
`ifdef ITER_MULDIV_SAT_EN
   assign mul_res = ovf_q ? '1 : acc_q;
`else
   assign mul_res = acc_q;
`endif
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      result_d = result_q;
      rem_d    = rem_q;
      ovf_d    = ovf_q;
      dbz_d    = dbz_q;
      busy_d   = state_q != IDLE;
      done_d   = state_q == DONE;
      case (state_q)
         IDLE: if (bus.start) begin
            op_d    = op_e'(bus.op);
            a_d     = bus.opa;
            b_d     = bus.opb;
            ovf_d   = 1'b0;
            dbz_d   = bus.op && bus.opb == '0;
            acc_d   = bus.op ? bus.opa : '0;
            cnt_d   = bus.opb;
            quo_d   = dbz_d ? '1 : '0;
            state_d = bus.opb == '0 ? DONE : bus.op ? DIV : MUL;
         end
         MUL: begin
            acc_d   = sum;
            ovf_d   = ovf_q | cout;
            cnt_d   = cnt_q - WIDTH'(1);
            state_d = cnt_q == WIDTH'(1) ? DONE : MUL;
         end
         DIV: begin
            acc_d   = cout ? acc_q : sum;
            quo_d   = cout ? quo_q : quo_q + WIDTH'(1);
            state_d = cout ? DONE : DIV;
         end
         DONE: begin
            result_d = op_q == OP_DIV ? quo_q : mul_res;
            rem_d    = op_q == OP_DIV ? acc_q : '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (!reset) begin
         state_q  <= IDLE;
         op_q     <= OP_MUL;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         quo_q    <= '0;
         result_q <= '0;
         rem_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         dbz_q    <= dbz_d;
      end
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.remainder = rem_q;
   assign bus.ovf       = ovf_q;
   assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_iter_muldiv_ctrl.sv
// tb_iter_muldiv_ctrl: directed and randomized checks of iter_muldiv_ctrl against
// an arithmetic reference (product, quotient, remainder, latency).
module tb_iter_muldiv_ctrl;
   import iter_muldiv_pkg::*;
   localparam int W    = DEFAULT_WIDTH;
   localparam int MAXV = (1 << W) - 1;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   iter_muldiv_ctrl_if #(.WIDTH(W)) bus ();
   iter_muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic void model(input bit op, input int a, input int b, output int res,
                                 output int rem, output bit ovf, output bit dbz, output int lat);
      int p;
      p   = a * b;
      ovf = 1'b0;
      dbz = 1'b0;
      rem = 0;
      if (!op) begin
         ovf = p > MAXV;
`ifdef ITER_MULDIV_SAT_EN
         res = ovf ? MAXV : p;
`else
         res = p % (MAXV + 1);
`endif
         lat = (b == 0) ? 1 : b + 1;
      end else if (b == 0) begin
         dbz = 1'b1;
         res = MAXV;
         rem = a;
         lat = 1;
      end else begin
         res = a / b;
         rem = a % b;
         lat = a / b + 2;
      end
   endfunction
   // start is presented for one edge; returns cycles until done (-1 on timeout) and busy cycle count
   task automatic do_op(input bit op, input int a, input int b, output int lat, output int busy_n);
      bus.start = 1'b1;
      bus.op    = op;
      bus.opa   = W'(a);
      bus.opb   = W'(b);
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat       = -1;
      busy_n    = 0;
      for (int n = 1; n <= 600; n++) begin
         @(posedge clk); #1;
         busy_n += int'(bus.busy);
         if (bus.done) begin
            lat = n;
            break;
         end
      end
   endtask
   task automatic test_reset();
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.opa   = '0;
      bus.opb   = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.result, bus.remainder, bus.ovf, bus.dbz} !== '0)
         $display("FAIL reset_outputs busy=%b done=%b result=%0d rem=%0d ovf=%b dbz=%b required all 0",
                  bus.busy, bus.done, bus.result, bus.remainder, bus.ovf, bus.dbz);
      if ({bus.busy, bus.done, bus.result, bus.remainder, bus.ovf, bus.dbz} !== '0) failures++;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask
   task automatic test_directed();
      bit ops [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      int as  [6] = '{9, 20, 9, 3, 9, 5};
      int bs  [6] = '{2, 13, 2, 7, 0, 0};
      int res, rem, lat, got_lat, busy_n;
      bit ovf, dbz;
      for (int i = 0; i < 6; i++) begin
         model(ops[i], as[i], bs[i], res, rem, ovf, dbz, lat);
         do_op(ops[i], as[i], bs[i], got_lat, busy_n);
         checks++;
         if (got_lat !== lat) begin
            failures++;
            $display("FAIL dir%0d_latency got=%0d exp=%0d", i, got_lat, lat);
         end
         checks++;
         if (int'(bus.result) !== res || int'(bus.remainder) !== rem) begin
            failures++;
            $display("FAIL dir%0d_value result=%0d rem=%0d exp result=%0d rem=%0d",
                     i, bus.result, bus.remainder, res, rem);
         end
         checks++;
         if (bus.ovf !== ovf || bus.dbz !== dbz) begin
            failures++;
            $display("FAIL dir%0d_flags ovf=%b dbz=%b exp ovf=%b dbz=%b", i, bus.ovf, bus.dbz, ovf, dbz);
         end
         checks++;
         if (busy_n !== lat) begin
            failures++;
            $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, busy_n, lat);
         end
      end
   endtask
   task automatic test_random();
      bit op;
      int a, b, res, rem, lat, got_lat, busy_n;
      bit ovf, dbz;
      for (int i = 0; i < 40; i++) begin
         op = 1'($urandom_range(0, 1));
         a  = int'($urandom_range(0, MAXV));
         b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MAXV));
         model(op, a, b, res, rem, ovf, dbz, lat);
         do_op(op, a, b, got_lat, busy_n);
         checks++;
         if (got_lat !== lat || busy_n !== lat) begin
            failures++;
            $display("FAIL rnd%0d_timing op=%0d a=%0d b=%0d lat=%0d busy=%0d exp=%0d",
                     i, op, a, b, got_lat, busy_n, lat);
         end
         checks++;
         if (int'(bus.result) !== res || int'(bus.remainder) !== rem || bus.ovf !== ovf || bus.dbz !== dbz) begin
            failures++;
            $display("FAIL rnd%0d_value op=%0d a=%0d b=%0d got %0d/%0d/%b/%b exp %0d/%0d/%b/%b",
                     i, op, a, b, bus.result, bus.remainder, bus.ovf, bus.dbz, res, rem, ovf, dbz);
         end
      end
   endtask
   task automatic test_ignore_start();
      int lat = -1;
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.opa   = W'(10);
      bus.opb   = W'(5);
      @(posedge clk); #1;
      for (int n = 1; n <= 40; n++) begin
         bus.start = (n == 2 || n == 6);
         bus.op    = bus.start;
         bus.opa   = bus.start ? W'(99) : W'(10);
         bus.opb   = bus.start ? W'(3) : W'(5);
         @(posedge clk); #1;
         if (bus.done) begin
            lat = n;
            break;
         end
      end
      bus.start = 1'b0;
      checks++;
      if (lat !== 6 || bus.result !== W'(50) || bus.remainder !== '0) begin
         failures++;
         $display("FAIL ignore_start lat=%0d result=%0d rem=%0d exp lat=6 result=50 rem=0",
                  lat, bus.result, bus.remainder);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL start_not_queued busy=%b done=%b exp 0 0", bus.busy, bus.done);
      end
   endtask
   task automatic test_back_to_back();
      int lat, busy_n;
      do_op(1'b0, 7, 3, lat, busy_n);
      checks++;
      if (lat !== 4 || bus.result !== W'(21)) begin
         failures++;
         $display("FAIL b2b_first lat=%0d result=%0d exp lat=4 result=21", lat, bus.result);
      end
      do_op(1'b1, 100, 7, lat, busy_n);
      checks++;
      if (lat !== 16 || bus.result !== W'(14) || bus.remainder !== W'(2)) begin
         failures++;
         $display("FAIL b2b_second lat=%0d result=%0d rem=%0d exp lat=16 result=14 rem=2",
                  lat, bus.result, bus.remainder);
      end
   endtask
   task automatic test_abort();
      int lat, busy_n;
      bit seen = 1'b0;
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.opa   = W'(7);
      bus.opb   = W'(200);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({bus.busy, bus.done, bus.result, bus.remainder, bus.ovf, bus.dbz} !== '0) begin
         failures++;
         $display("FAIL abort_outputs busy=%b done=%b result=%0d rem=%0d ovf=%b dbz=%b required all 0",
                  bus.busy, bus.done, bus.result, bus.remainder, bus.ovf, bus.dbz);
      end
      reset = 1'b1;
      repeat (210) begin
         @(posedge clk); #1;
         seen |= bus.done | bus.busy;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_done activity=%b exp 0", seen);
      end
      do_op(1'b0, 3, 3, lat, busy_n);
      checks++;
      if (lat !== 4 || bus.result !== W'(9) || bus.ovf !== 1'b0) begin
         failures++;
         $display("FAIL after_abort lat=%0d result=%0d ovf=%b exp lat=4 result=9 ovf=0", lat, bus.result, bus.ovf);
      end
   endtask
   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_random();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
